// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: digit width and FSM state encoding.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// Existing 4-bit ripple-carry adder, reused as the single time-shared digit adder.
module rippleCarryAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c4
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple-carry adder, processing one nibble per clock
// (LS nibble first) with the inter-nibble carry held in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NIB_W-1:0] rca_a, rca_b, rca_sum;
    logic             rca_c4;

    // Select the current digit of each latched operand for the shared adder.
    always_comb begin
        rca_a = a_q[int'(idx_q) * NIB_W +: NIB_W];
        rca_b = b_q[int'(idx_q) * NIB_W +: NIB_W];
    end

    rippleCarryAdder u_rca (
        .a   (rca_a),
        .b   (rca_b),
        .cin (carry_q),
        .sum (rca_sum),
        .c4  (rca_c4)
    );

    // Next-state logic: accept operands, step through digits, hold result until taken.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[int'(idx_q) * NIB_W +: NIB_W] = rca_sum;
                carry_d = rca_c4;
                if (idx_q == IDX_LAST) begin
                    cout_d  = rca_c4;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake and status outputs decode the state register only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with NIBBLES=4 (16-bit operands).
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: unsigned addition with one extra bit for the carry out.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Accept one operand pair, then wait (bounded) for out_valid with out_ready low.
    // Reports edges from accept to out_valid and whether busy/in_ready misbehaved meanwhile.
    task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v,
                         output logic [W-1:0] s, output logic co, output int lat,
                         output bit timed_out, output bit bad_hs);
        @(negedge clk);
        a = a_v; b = b_v; cin = c_v; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 0; timed_out = 1'b1; bad_hs = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
            if (busy !== 1'b1 || in_ready !== 1'b0) bad_hs = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        s = sum; co = cout;
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, want 1 0 0 0000 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic co; int lat; bit to, bad;
        logic [W-1:0] va [3] = '{16'h0006, 16'hFFFF, 16'h1234};
        logic [W-1:0] vb [3] = '{16'h000C, 16'h0001, 16'h4321};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   ex [3] = '{17'h0_0012, 17'h1_0000, 17'h0_5556};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], s, co, lat, to, bad);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL basic_timeout[%0d]: out_valid never rose", i);
            end
            checks++;
            if (lat != N) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d edges, want %0d", i, lat, N);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL basic_busy[%0d]: busy/in_ready wrong during ADD, want busy=1 in_ready=0", i);
            end
            checks++;
            if ({co, s} !== ex[i]) begin
                errors++;
                $display("FAIL basic_sum[%0d]: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, co, s, ex[i][W], ex[i][W-1:0]);
            end
            take_result();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_release[%0d]: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                         i, in_ready, out_valid, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s; logic co; int lat; bit to, bad;
        do_op(16'h0E77, 16'h706E, 1'b0, s, co, lat, to, bad);
        checks++;
        if (to || {co, s} !== 17'h0_7EE5) begin
            errors++;
            $display("FAIL bp_result: timeout=%b cout=%b sum=%h, want cout=0 sum=7ee5", to, co, s);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h7EE5 || cout !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b, want 1 0 7ee5 0",
                         k, out_valid, in_ready, sum, cout);
            end
        end
        take_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 16'h3333 || cout !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_first: out_valid=%b sum=%h cout=%b, want 1 3333 0", out_valid, sum, cout);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_second: out_valid=%b sum=%h cout=%b, want 1 ffff 0", out_valid, sum, cout);
        end
        take_result();
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] s; logic co; int lat; bit to, bad;
        @(negedge clk);
        a = 16'h9999; b = 16'h8888; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b, want 1 0 0 0000 0",
                     in_ready, out_valid, busy, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0002, 16'h0009, 1'b0, s, co, lat, to, bad);
        checks++;
        if (to || lat != N || {co, s} !== 17'h0_000B) begin
            errors++;
            $display("FAIL reset_recover: timeout=%b lat=%0d cout=%b sum=%h, want 0 %0d 0 000b", to, lat, co, s, N);
        end
        take_result();
    endtask

    task automatic test_random();
        logic [W-1:0] s, ra, rb; logic co, rc; int lat; bit to, bad;
        logic [W:0] ex;
        int stall;
        int bad_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
            ex = ref_add(ra, rb, rc);
            do_op(ra, rb, rc, s, co, lat, to, bad);
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                @(negedge clk);
            end
            checks++;
            if (to || lat != N || bad || {cout, sum} !== ex || out_valid !== 1'b1) begin
                errors++;
                bad_cnt++;
                if (bad_cnt <= 10)
                    $display("FAIL random[%0d]: a=%h b=%h cin=%b got cout=%b sum=%h lat=%0d to=%b, want cout=%b sum=%h",
                             i, ra, rb, rc, cout, sum, lat, to, ex[W], ex[W-1:0]);
            end
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequential multi-word adder built around the team's existing 4-bit ripple-carry adder (rippleCarryAdder: a[3:0], b[3:0], cin, sum[3:0], c4). It accepts two wide operands through a valid/ready handshake and adds them one nibble per clock, least-significant nibble first. Carry passes between nibbles through a register. The result is presented on a valid/ready output port. It sits directly upstream of rippleCarryAdder: it feeds that adder its nibble operands and consumes its sum and carry.

Parameters:
NIBBLES, 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES); legal range 1..16

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair and cin are valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  initial carry-in
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  W  registered sum
cout  output  1  carry out of the most-significant nibble
busy  output  1  high in ADD or DONE

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low. All state clears immediately on rst_n=0, with no clock edge needed.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0, internal carry=0, nibble index=0, operand registers=0.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a and b, set carry=cin, set idx=0, go to ADD.
- ADD:
  - in_ready=0.
  - Each cycle, the sub-adder gets a_reg[4*idx+:4], b_reg[4*idx+:4] and carry.
  - At the edge: write the sub-adder sum into sum_reg[4*idx+:4], set carry=c4, set idx=idx+1.
  - When idx==NIBBLES-1 at the edge: cout=c4, go to DONE. idx returns to 0.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_valid&&out_ready: go to IDLE, out_valid=0.
- Latency: the accept edge is E0. out_valid goes high after edge E0+NIBBLES, i.e. NIBBLES+1 edges including the accept. Throughput is one operation per NIBBLES+2 cycles when out_ready=1.
- Outputs are registered only; there is no combinational path from in_valid or out_ready to out_valid or sum.
- in_valid is ignored while busy. Operand inputs may change freely after acceptance.
- Arithmetic: unsigned, modulo 2^W. cout is the carry out of bit W-1. Overflow is not flagged beyond cout.
- sum is written nibble by nibble during ADD, so intermediate values are visible. Its value is only meaningful while out_valid=1.
- Reset mid-operation (ADD or DONE): the in-flight result is discarded. The block is back in IDLE with all outputs at reset values on the first edge after rst_n releases.
- NIBBLES=1: ADD lasts exactly one cycle.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and the nibble width constant (4).
- The index register width is derived locally as $clog2(NIBBLES), minimum 1.
- One sub-module: the existing rippleCarryAdder, instantiated once and time-multiplexed across nibbles. No new sub-modules.

Test Plan:
- NIBBLES=4; a=0x0006, b=0x000C, cin=0; accept at edge 0 -> out_valid rises after edge 4; sum=0x0012, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all nibbles; sum=0x0000, cout=1. Also a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
- Back-pressure: after the result 0x7EE5 (a=0x0E77, b=0x706E, cin=0), hold out_ready=0 for 3 cycles -> out_valid, sum and cout stay stable; in_ready=0 throughout; release -> IDLE next edge.
- Busy-ignore: drive in_valid=1 with a=0xAAAA, b=0x5555 during ADD -> it is not accepted, and the original result is unchanged. That pair is accepted only once the block is back in IDLE -> sum=0xFFFF, cout=0.
- Reset mid-op: assert rst_n=0 asynchronously two cycles into ADD -> outputs go to reset values immediately. After release, a new operation a=0x0002, b=0x0009 -> sum=0x000B, cout=0.
- Random: 1000 random a, b, cin with random out_ready stalls -> {cout,sum} == a+b+cin every time.
